pea_stream_tx: RTL and testbench

//   Stream transmitter feeding one PEA input port: fetches len_i words from a memory bank at

---
 rtl/pea_stream_tx_pkg.sv | 17 +
 rtl/pea_stream_tx_if.sv | 38 +++
 rtl/pea_stream_tx_fifo.sv | 61 ++++++
 rtl/pea_stream_tx.sv | 152 +++++++++++++++
 tb/tb_pea_stream_tx.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pea_stream_tx_pkg.sv
// Shared types and defaults for the PEA stream transmitter.
package pea_stream_tx_pkg;

    localparam int STREAM_TX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_FETCH = 2'd1,
        TX_DRAIN = 2'd2
    } stream_tx_state_t;

    // Occupancy counters must hold the value DEPTH itself, hence one bit more than the pointer.
    function automatic int stream_tx_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pea_stream_tx_if.sv
// Memory read port and PE operand stream of one PEA input column.
interface pea_stream_tx_if #(
    parameter int N_BITS = 32,
    parameter int ADDR_W = 32
);

    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [N_BITS-1:0] mem_rdata;
    logic [N_BITS-1:0] stream_data;
    logic              stream_valid;
    logic              stream_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata,
        output stream_data,
        output stream_valid,
        input  stream_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata,
        input  stream_data,
        input  stream_valid,
        output stream_ready
    );

endinterface

// File: rtl/pea_stream_tx_fifo.sv
// Synchronous read-data buffer; the head is read straight from storage registers,
// so nothing combinational reaches it from the write side.
module pea_stream_tx_fifo
    import pea_stream_tx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = STREAM_TX_FIFO_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = stream_tx_cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CNT_W'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same edge, so push into a full buffer is fine then.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assert property (@(posedge clk_i) disable iff (rst_i) !(push && full && !pop));

endmodule

// File: rtl/pea_stream_tx.sv
// Stream transmitter: strided memory fetch into a small buffer, replayed as a PE operand stream.
// Optional build macro PEA_STREAM_TX_REPEAT_EN adds rep_i: each element is presented rep+1 times.
module pea_stream_tx
    import pea_stream_tx_pkg::*;
#(
    parameter int N_BITS     = 32,
    parameter int ADDR_W     = 32,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = STREAM_TX_FIFO_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [LEN_W-1:0]  len_i,
`ifdef PEA_STREAM_TX_REPEAT_EN
    input  logic [7:0]        rep_i,
`endif
    pea_stream_tx_if.master   bus,
    output logic              busy_o,
    output logic              done_o
);

    localparam int CNT_W = stream_tx_cnt_width(FIFO_DEPTH);
    localparam int SUM_W = CNT_W + 1;

    stream_tx_state_t  state;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] stride_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  issued;
    logic [LEN_W-1:0]  sent;
    logic [CNT_W-1:0]  outstanding;
    logic              done_q;

    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              credit_ok;
    logic              gnt_fire;
    logic              rsp_fire;
    logic              hs;
    logic              pop;
    logic              last_pop;

    // Buffered plus in-flight words may never exceed the buffer, so every response has a slot.
    // Credit only shrinks through a grant, so a raised request is never withdrawn.
    assign credit_ok = (SUM_W'(fifo_count) + SUM_W'(outstanding)) < SUM_W'(FIFO_DEPTH);

    assign bus.mem_req  = (state == TX_FETCH) && (issued != len_q) && credit_ok;
    assign bus.mem_addr = addr_q;

    assign gnt_fire = bus.mem_req && bus.mem_gnt;
    // Responses to reads abandoned by a reset arrive while idle and are dropped.
    assign rsp_fire = bus.mem_rvalid && (state != TX_IDLE);
    assign hs       = bus.stream_valid && bus.stream_ready;

`ifdef PEA_STREAM_TX_REPEAT_EN
    logic [7:0] rep_q;
    logic [7:0] rep_cnt;

    assign pop = hs && (rep_cnt == rep_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rep_q   <= '0;
            rep_cnt <= '0;
        end else if (state == TX_IDLE) begin
            rep_cnt <= '0;
            if (start_i) rep_q <= rep_i;
        end else if (hs) begin
            rep_cnt <= (rep_cnt == rep_q) ? '0 : rep_cnt + 8'd1;
        end
    end
`else
    assign pop = hs;
`endif

    assign last_pop = pop && ((sent + LEN_W'(1)) == len_q);

    pea_stream_tx_fifo #(
        .WIDTH (N_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (rsp_fire),
        .wdata (bus.mem_rdata),
        .pop   (pop),
        .head  (bus.stream_data),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.stream_valid = !fifo_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= TX_IDLE;
            len_q       <= '0;
            stride_q    <= '0;
            addr_q      <= '0;
            issued      <= '0;
            sent        <= '0;
            outstanding <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            unique case (state)
                TX_IDLE: begin
                    if (start_i) begin
                        len_q    <= len_i;
                        stride_q <= stride_i;
                        addr_q   <= base_addr_i;
                        issued   <= '0;
                        sent     <= '0;
                        if (len_i == '0) done_q <= 1'b1;
                        else             state  <= TX_FETCH;
                    end
                end
                TX_FETCH: begin
                    if (gnt_fire) begin
                        addr_q <= addr_q + stride_q;
                        issued <= issued + LEN_W'(1);
                        if ((issued + LEN_W'(1)) == len_q) state <= TX_DRAIN;
                    end
                end
                TX_DRAIN: begin
                end
                default: state <= TX_IDLE;
            endcase

            if (gnt_fire && !rsp_fire)      outstanding <= outstanding + CNT_W'(1);
            else if (!gnt_fire && rsp_fire) outstanding <= outstanding - CNT_W'(1);

            // The last element can only leave once every request has been granted,
            // so this never collides with the FETCH to DRAIN step above.
            if (pop) begin
                sent <= sent + LEN_W'(1);
                if (last_pop) begin
                    state  <= TX_IDLE;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy_o = (state != TX_IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_pea_stream_tx.sv
// Bench for pea_stream_tx: memory model with latency and random grants, scoreboard of expected stream words.
module tb_pea_stream_tx;
    import pea_stream_tx_pkg::*;

    localparam int N_BITS = 32;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;
    localparam int DEPTH  = STREAM_TX_FIFO_DEPTH;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] stride_i;
    logic [LEN_W-1:0]  len_i;
`ifdef PEA_STREAM_TX_REPEAT_EN
    logic [7:0]        rep_i;
`endif
    logic              busy_o;
    logic              done_o;

    pea_stream_tx_if #(.N_BITS(N_BITS), .ADDR_W(ADDR_W)) bus ();

    pea_stream_tx #(
        .N_BITS     (N_BITS),
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .len_i       (len_i),
`ifdef PEA_STREAM_TX_REPEAT_EN
        .rep_i       (rep_i),
`endif
        .bus         (bus),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] stride;
        int          len;
        int          lat;
        int          gnt_pct;
        int          rdy_pct;
        bit          stall;
        int          exp_first;  // cycles from start to first valid, -1 = not checked
        logic [31:0] exp_last;   // address of the final request
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int lat = 1;
    int gnt_pct = 100;
    int rdy_pct = 100;
    bit stall_en = 0;
    int stall_from = 0;
    int stall_to = 0;
    int rep_v = 0;
    bit rst_drive = 1;
    bit start_pending = 0;

    rsp_t        pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [31:0] cur_stride;
    logic [31:0] last_addr;
    int n_gnt, n_pop, n_hs, n_done, n_req_cyc, rep_seen, max_fill, first_valid_cyc;
    int last_hs_cyc = -10;
    bit prev_req_pend = 0;
    bit prev_stall = 0;
    bit got_done = 0;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
    endfunction

    // One clock: observe at the falling edge, drive inputs, predict what the next rising edge accepts.
    task automatic cycle();
        bit g;
        bit r;
        @(negedge clk);
        if (prev_req_pend)
            check("req_hold", {31'b0, bus.mem_req, bus.mem_addr}, {31'b0, 1'b1, prev_addr});
        if (prev_stall)
            check("data_hold", {31'b0, bus.stream_valid, bus.stream_data}, {31'b0, 1'b1, prev_data});
        if (done_o) begin
            n_done++;
            got_done = 1;
            check("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
        end
        if (bus.mem_req) n_req_cyc++;
        if (bus.stream_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (stall_en && cyc == stall_to)
            check("stall_fill", {31'b0, bus.mem_req, 32'(n_gnt - n_pop)}, {32'b0, 32'(DEPTH)});

        g = int'($urandom_range(99)) < gnt_pct;
        r = !(stall_en && cyc >= stall_from && cyc <= stall_to) && (int'($urandom_range(99)) < rdy_pct);
        rst_i = rst_drive;
        start_i = start_pending;
        start_pending = 0;
        bus.mem_gnt = g;
        bus.stream_ready = r;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata = pend[0].data;
            void'(pend.pop_front());
        end else begin
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata = $urandom;
        end

        if (!rst_drive) begin
            if (bus.mem_req && g) begin
                check("mem_addr", 64'(bus.mem_addr), 64'(exp_addr));
                last_addr = bus.mem_addr;
                exp_q.push_back(mem_fn(exp_addr));
                pend.push_back('{cyc + lat, mem_fn(bus.mem_addr)});
                exp_addr = exp_addr + cur_stride;
                n_gnt++;
            end
            if (n_gnt - n_pop > max_fill) max_fill = n_gnt - n_pop;
            if (bus.stream_valid && r) begin
                check("stream_data_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("stream_data", 64'(bus.stream_data), 64'(exp_q[0]));
                    rep_seen++;
                    if (rep_seen == rep_v + 1) begin
                        void'(exp_q.pop_front());
                        rep_seen = 0;
                        n_pop++;
                    end
                end
                n_hs++;
                last_hs_cyc = cyc;
            end
        end
        prev_req_pend = bus.mem_req && !g && !rst_drive;
        prev_addr = bus.mem_addr;
        prev_stall = bus.stream_valid && !r && !rst_drive;
        prev_data = bus.stream_data;
        cyc++;
    endtask

    task automatic clear_model();
        exp_q.delete();
        n_gnt = 0; n_pop = 0; n_hs = 0; n_done = 0; n_req_cyc = 0;
        rep_seen = 0; max_fill = 0; first_valid_cyc = -1;
        got_done = 0;
    endtask

    task automatic run_xfer(input vec_t v);
        int start_cyc;
        clear_model();
        lat = v.lat;
        gnt_pct = v.gnt_pct;
        rdy_pct = v.rdy_pct;
        exp_addr = v.base;
        cur_stride = v.stride;
        base_addr_i = v.base;
        stride_i = v.stride;
        len_i = LEN_W'(v.len);
`ifdef PEA_STREAM_TX_REPEAT_EN
        rep_i = 8'(rep_v);
`endif
        start_cyc = cyc;
        if (v.len == 0) last_hs_cyc = cyc;
        stall_en = v.stall;
        stall_from = cyc + 6;
        stall_to = cyc + 25;
        start_pending = 1;
        for (int k = 0; k < 3000 && !got_done; k++) cycle();
        check("done_seen", 64'(got_done), 64'd1);
        cycle();
        check("busy_after_done", 64'(busy_o), 64'd0);
        check("done_count", 64'(n_done), 64'd1);
        check("req_count", 64'(n_gnt), 64'(v.len));
        check("elem_count", 64'(n_pop), 64'(v.len));
        check("hs_count", 64'(n_hs), 64'(v.len * (rep_v + 1)));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("mem_drained", 64'(pend.size()), 64'd0);
        check("credit_bound", 64'(max_fill <= DEPTH), 64'd1);
        if (v.len == 0) check("no_req", 64'(n_req_cyc), 64'd0);
        else            check("last_addr", 64'(last_addr), 64'(v.exp_last));
        if (v.exp_first >= 0) check("first_latency", 64'(first_valid_cyc - start_cyc), 64'(v.exp_first));
        stall_en = 0;
    endtask

    vec_t vecs[6];
    vec_t v_after_rst;
    vec_t v_rep;

    initial begin
        vecs[0] = '{32'h0000_0100, 32'd4,          8,  1, 100, 100, 0,  3, 32'h0000_011C};
        vecs[1] = '{32'h0000_0200, 32'd8,          0,  1, 100, 100, 0, -1, 32'h0000_0000};
        vecs[2] = '{32'h0000_1000, 32'd4,          24, 5, 50,  50,  0, -1, 32'h0000_105C};
        vecs[3] = '{32'h0000_2000, 32'd16,         16, 2, 100, 100, 1, -1, 32'h0000_20F0};
        vecs[4] = '{32'h0000_0004, 32'hFFFF_FFFC,  3,  1, 100, 100, 0,  3, 32'hFFFF_FFFC};
        vecs[5] = '{32'hFFFF_FFF8, 32'd4,          4,  3, 100, 100, 0,  5, 32'h0000_0004};
        v_after_rst = '{32'h0000_0400, 32'd4, 2, 1, 100, 100, 0, 3, 32'h0000_0404};
        v_rep       = '{32'h0000_0500, 32'd4, 2, 1, 100, 100, 0, 3, 32'h0000_0504};

        rst_i = 1'b1;
        start_i = 1'b0;
        base_addr_i = '0;
        stride_i = '0;
        len_i = '0;
`ifdef PEA_STREAM_TX_REPEAT_EN
        rep_i = '0;
`endif
        bus.mem_gnt = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata = '0;
        bus.stream_ready = 1'b0;
        clear_model();

        rst_drive = 1;
        repeat (3) cycle();
        @(posedge clk); #1;
        check("reset_ctrl", {60'b0, bus.mem_req, bus.stream_valid, busy_o, done_o}, 64'd0);
        check("reset_addr_data", {bus.mem_addr, bus.stream_data}, 64'd0);
        rst_drive = 0;

        for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

        // Reset with two reads in flight, then make sure their late responses are ignored.
        clear_model();
        lat = 5; gnt_pct = 100; rdy_pct = 0;
        exp_addr = 32'h300; cur_stride = 32'd4;
        base_addr_i = 32'h300; stride_i = 32'd4; len_i = 16'd8;
        start_pending = 1;
        repeat (3) cycle();
        check("inflight_before_rst", 64'(pend.size()), 64'd2);
        gnt_pct = 0;
        rst_drive = 1;
        cycle();
        @(posedge clk); #1;
        check("rst_mid_ctrl", {60'b0, bus.mem_req, bus.stream_valid, busy_o, done_o}, 64'd0);
        check("rst_mid_addr_data", {bus.mem_addr, bus.stream_data}, 64'd0);
        rst_drive = 0;
        prev_req_pend = 0;
        prev_stall = 0;
        clear_model();
        gnt_pct = 100; rdy_pct = 100;
        repeat (10) cycle();
        check("late_rsp_consumed", 64'(pend.size()), 64'd0);
        check("late_rsp_ignored", {62'b0, bus.stream_valid, busy_o}, 64'd0);
        check("idle_no_valid", 64'(first_valid_cyc), 64'hFFFF_FFFF_FFFF_FFFF);
        run_xfer(v_after_rst);

`ifdef PEA_STREAM_TX_REPEAT_EN
        rep_v = 2;
        run_xfer(v_rep);
        rep_v = 0;
`else
        run_xfer(v_rep);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
